// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and load/store, one transaction at a time.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_wr,
  input  logic [2:0]  ls_rw_type,
  input  logic [31:0] ls_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_rw_type,
  output logic [31:0] mem_dat_i,
  input  logic [31:0] mem_dat_o,
  output logic        busy
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT, ST_RESP} state_t;

  state_t             state_q, state_d;
  logic               own_if_q, own_if_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         type_q, type_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        ls_rdata_q, ls_rdata_d;

  logic idle, cmd, force_if, if_win, ls_win, if_hs, ls_hs;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [STV_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STV_W'(STARVE_MAX));

  // Counts load/store wins that left a waiting fetch behind; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (if_hs) begin
      starve_d = '0;
    end else if (ls_hs && if_req_valid && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Ready is gated by rst_n so every output reads zero while reset is held.
  assign idle   = (state_q == ST_IDLE) && rst_n;
  assign cmd    = (state_q == ST_CMD);
  assign if_win = if_req_valid && (!ls_req_valid || force_if);
  assign ls_win = ls_req_valid && !(force_if && if_req_valid);

  assign if_req_ready = idle && if_win;
  assign ls_req_ready = idle && ls_win;
  assign if_hs        = if_req_ready;
  assign ls_hs        = ls_req_ready;

  always_comb begin
    state_d    = state_q;
    own_if_d   = own_if_q;
    addr_d     = addr_q;
    type_d     = type_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_hs) begin
          own_if_d = 1'b1;
          addr_d   = if_addr;
          type_d   = 3'b010;
          wr_d     = 1'b0;
          wdata_d  = '0;
          state_d  = ST_CMD;
        end else if (ls_hs) begin
          own_if_d = 1'b0;
          addr_d   = ls_addr;
          type_d   = ls_rw_type;
          wr_d     = ls_wr;
          wdata_d  = ls_wdata;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: RAM data is valid now, so it lands in rdata for the RESP cycle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          if (own_if_q) begin
            if_rdata_d = mem_dat_o;
          end else begin
            ls_rdata_d = wr_q ? 32'h0 : mem_dat_o;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      own_if_q   <= 1'b0;
      addr_q     <= '0;
      type_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      own_if_q   <= own_if_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_rd       = cmd && !wr_q;
  assign mem_wr       = cmd && wr_q;
  assign mem_addr     = cmd ? addr_q : 32'h0;
  assign mem_rw_type  = cmd ? type_q : 3'b000;
  assign mem_dat_i    = cmd ? wdata_q : 32'h0;
  assign if_rsp_valid = (state_q == ST_RESP) && own_if_q;
  assign ls_rsp_valid = (state_q == ST_RESP) && !own_if_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
